// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump streamer.
// Holds the two-state FSM encoding and the default sizing constants
// used by reg_dump_streamer and its integration wrapper.
package reg_dump_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_IDX_W    = 5;
  localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/reg_dump_streamer.sv
// Debug readout unit for the CPU register file.
// On a dump request all registers are snapshotted in one cycle and then
// streamed out one word per beat over a valid/ready interface.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset, clears all state
//   reg_flat   - concatenated register outputs, reg i at [i*DATA_W +: DATA_W]
//   dump_req   - request a dump, sampled every rising edge
//   out_valid  - current beat is valid
//   out_ready  - consumer accepts the beat when out_valid && out_ready
//   out_data   - snapshot value of register out_idx
//   out_idx    - register index of the current beat
//   out_last   - high on the beat carrying the last register
//   busy       - a dump is in progress
//   pending    - one queued request is waiting
//   overflow   - sticky, a request was dropped because one was already queued
//   dump_count - completed dumps, wraps modulo 2**CNT_W
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  input  logic                       dump_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       pending,
  output logic                       overflow,
  output logic [CNT_W-1:0]           dump_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] snap_q [NUM_REGS];
  logic [DATA_W-1:0] snap_d [NUM_REGS];

  logic fire;
  logic last_beat;
  logic capture;

  assign fire      = (state_q == SEND) && out_ready;
  assign last_beat = (idx_q == LAST_IDX);

  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // A request landing on the last handshake restarts directly
        // instead of queueing, so it must not also set pending.
        if (dump_req) begin
          if (pending_q) begin
            overflow_d = 1'b1;
          end else if (!(fire && last_beat)) begin
            pending_d = 1'b1;
          end
        end

        if (fire) begin
          if (!last_beat) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            count_d = count_q + CNT_W'(1);
            idx_d   = '0;
            if (pending_q || dump_req) begin
              // Back-to-back restart: fresh snapshot, no idle gap.
              capture   = 1'b1;
              pending_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    if (capture) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_d[i] = reg_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the snapshot array is deliberately left out of reset; its
  // contents are never visible outside SEND, and leaving it unreset
  // lets it map onto plain storage without a reset network.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  // Outputs come only from registered state; out_data is gated so it reads
  // zero whenever no beat is offered, including immediately under reset.
  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_valid ? snap_q[idx_q] : '0;
  assign out_idx    = idx_q;
  assign out_last   = out_valid && last_beat;
  assign pending    = pending_q;
  assign overflow   = overflow_q;
  assign dump_count = count_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: a cycle-level reference model
// of the dump protocol compared against the DUT every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_reg_dump_streamer;

  localparam int NR = 32;
  localparam int DW = 32;

  logic           clk;
  logic           rst;
  logic [NR*DW-1:0] reg_flat;
  logic           dump_req;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [4:0]     out_idx;
  logic           out_last;
  logic           busy;
  logic           pending;
  logic           overflow;
  logic [7:0]     dump_count;

  reg_dump_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .reg_flat  (reg_flat),
    .dump_req  (dump_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow),
    .dump_count(dump_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what the stream must look like: whether a dump is active, which
  // register is on offer, the image taken at dump start, the queued request,
  // the sticky drop flag and the completed-dump tally.
  bit          m_active  = 0;
  int          m_beat    = 0;
  bit          m_pending = 0;
  bit          m_overflow = 0;
  int          m_count   = 0;
  logic [31:0] m_img [NR];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_beat = 0; m_pending = 0; m_overflow = 0; m_count = 0;
    end else if (!m_active) begin
      if (dump_req) begin
        for (int i = 0; i < NR; i++) m_img[i] = reg_flat[i*DW +: DW];
        m_beat = 0;
        m_active = 1;
      end
    end else begin
      bit accepted, final_beat, had_pending;
      accepted    = out_ready;
      final_beat  = (m_beat == NR - 1);
      had_pending = m_pending;
      if (dump_req && had_pending) m_overflow = 1;
      if (dump_req && !had_pending && !(accepted && final_beat)) m_pending = 1;
      if (accepted) begin
        if (!final_beat) begin
          m_beat++;
        end else begin
          m_count = (m_count + 1) % 256;
          if (had_pending || dump_req) begin
            for (int i = 0; i < NR; i++) m_img[i] = reg_flat[i*DW +: DW];
            m_beat = 0;
            m_pending = 0;
          end else begin
            m_active = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cyc_valid",    out_valid,  m_active);
    check("cyc_busy",     busy,       m_active);
    check("cyc_pending",  pending,    m_pending);
    check("cyc_overflow", overflow,   m_overflow);
    check("cyc_count",    dump_count, m_count);
    if (m_active) begin
      check("cyc_idx",  out_idx,  m_beat);
      check("cyc_data", out_data, m_img[m_beat]);
      check("cyc_last", out_last, m_beat == NR - 1);
    end
  end

  // ---------------- handshake log ----------------
  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          last;
    int          cyc;
  } beat_t;

  beat_t log_q[$];
  int    cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready)
      log_q.push_back('{idx: int'(out_idx), data: out_data, last: out_last, cyc: cyc});
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_regs_inc();
    for (int i = 0; i < NR; i++) reg_flat[i*DW +: DW] = 32'h1000 + 32'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dump_req = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
    tick();
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    for (int k = 0; k < max_cyc; k++) begin
      if (!busy) break;
      tick();
    end
    check(nm, busy, 1'b0);
  endtask

  task automatic wait_idx(input int n, input int max_cyc, input string nm);
    bit found = 0;
    for (int k = 0; k < max_cyc; k++) begin
      if (out_valid && out_idx == 5'(n)) begin
        found = 1;
        break;
      end
      tick();
    end
    check(nm, found, 1'b1);
  endtask

  // Every logged beat must follow idx 0..31 repeating, data 0x1000+idx,
  // last only on idx 31.
  task automatic check_seq(input string nm);
    int bad = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k].idx != k % NR) bad++;
      if (log_q[k].data != 32'h1000 + 32'(k % NR)) bad++;
      if (log_q[k].last != (k % NR == NR - 1)) bad++;
    end
    check(nm, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    dump_req = 1'b0;
    out_ready = 1'b1;
    reg_flat = '0;
    set_regs_inc();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valid",    out_valid,  1'b0);
    check("rst_data",     out_data,   32'h0);
    check("rst_idx",      out_idx,    5'd0);
    check("rst_last",     out_last,   1'b0);
    check("rst_busy",     busy,       1'b0);
    check("rst_pending",  pending,    1'b0);
    check("rst_overflow", overflow,   1'b0);
    check("rst_count",    dump_count, 8'd0);

    // Basic dump, one-cycle latency, 32 back-to-back beats
    log_q.delete();
    pulse_req();
    check("basic_lat_valid", out_valid, 1'b1);
    check("basic_lat_data",  out_data,  32'h1000);
    check("basic_lat_idx",   out_idx,   5'd0);
    wait_idle(100, "basic_idle");
    check("basic_beats", log_q.size(), 32);
    if (log_q.size() == 32) begin
      check("basic_first", log_q[0].data, 32'h1000);
      check("basic_lastd", log_q[31].data, 32'h101F);
      check("basic_lasti", log_q[31].idx, 31);
      check("basic_gapless", log_q[31].cyc - log_q[0].cyc, 31);
    end
    check_seq("basic_seq");
    check("basic_count", dump_count, 8'd1);

    // Backpressure 1,0,0,1 plus reg_flat overwrite after the first beat
    do_reset();
    set_regs_inc();
    begin
      logic [3:0] pat = 4'b1001;
      dump_req = 1'b1;
      for (int k = 0; k < 400; k++) begin
        tick();
        dump_req = 1'b0;
        out_ready = pat[k % 4];
        if (log_q.size() >= 1) reg_flat = '1;
        if (!busy) break;
      end
    end
    out_ready = 1'b1;
    check("bp_idle", busy, 1'b0);
    check("bp_beats", log_q.size(), 32);
    check_seq("bp_seq");
    check("bp_count", dump_count, 8'd1);
    set_regs_inc();

    // Queued request during beat 10
    do_reset();
    pulse_req();
    wait_idx(10, 100, "q_reach10");
    pulse_req();
    check("q_pending", pending, 1'b1);
    wait_idle(200, "q_idle");
    check("q_beats", log_q.size(), 64);
    if (log_q.size() == 64) begin
      check("q_restart_idx", log_q[32].idx, 0);
      check("q_no_gap", log_q[32].cyc - log_q[31].cyc, 1);
    end
    check_seq("q_seq");
    check("q_count", dump_count, 8'd2);
    check("q_overflow", overflow, 1'b0);

    // Overflow: three requests inside one dump
    do_reset();
    pulse_req();
    wait_idx(5, 100, "ov_reach5");
    pulse_req();
    check("ov_pend1", pending, 1'b1);
    check("ov_flag1", overflow, 1'b0);
    wait_idx(10, 100, "ov_reach10");
    pulse_req();
    check("ov_flag2", overflow, 1'b1);
    wait_idx(15, 100, "ov_reach15");
    pulse_req();
    wait_idle(200, "ov_idle");
    check("ov_beats", log_q.size(), 64);
    check_seq("ov_seq");
    check("ov_count", dump_count, 8'd2);
    check("ov_sticky", overflow, 1'b1);

    // Asynchronous reset in the middle of beat 15
    do_reset();
    pulse_req();
    wait_idx(15, 100, "rm_reach15");
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid", out_valid,  1'b0);
    check("rm_data",  out_data,   32'h0);
    check("rm_idx",   out_idx,    5'd0);
    check("rm_last",  out_last,   1'b0);
    check("rm_busy",  busy,       1'b0);
    check("rm_count", dump_count, 8'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rm_after_valid", out_valid, 1'b0);
    check("rm_after_count", dump_count, 8'd0);
    check("rm_beats", log_q.size(), 15);

    // 256 back-to-back dumps via last-beat restart; counter wraps to 0
    do_reset();
    begin
      int sent = 0;
      for (int k = 0; k < 9000; k++) begin
        if (sent < 256 && ((!busy && sent == 0) || (out_valid && out_idx == 5'd31))) begin
          dump_req = 1'b1;
          sent++;
        end else begin
          dump_req = 1'b0;
        end
        tick();
        if (sent == 256 && !busy) break;
      end
      dump_req = 1'b0;
      check("wrap_sent", sent, 256);
    end
    check("wrap_idle", busy, 1'b0);
    check("wrap_beats", log_q.size(), 256 * NR);
    check_seq("wrap_seq");
    check("wrap_count", dump_count, 8'd0);
    check("wrap_overflow", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
